// File: rtl/aq_local_bus_arbiter.sv
// aq_local_bus_arbiter: round-robin share of one local-bus target between two masters,
// with an ACK timeout that completes the transaction with ERR_DATA.
module aq_local_bus_arbiter #(
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        M0_CS,
  input  logic        M0_RNW,
  input  logic [31:0] M0_ADDR,
  input  logic [3:0]  M0_BE,
  input  logic [31:0] M0_WDATA,
  output logic        M0_ACK,
  output logic [31:0] M0_RDATA,
  input  logic        M1_CS,
  input  logic        M1_RNW,
  input  logic [31:0] M1_ADDR,
  input  logic [3:0]  M1_BE,
  input  logic [31:0] M1_WDATA,
  output logic        M1_ACK,
  output logic [31:0] M1_RDATA,
  output logic        S_CS,
  output logic        S_RNW,
  output logic [31:0] S_ADDR,
  output logic [3:0]  S_BE,
  output logic [31:0] S_WDATA,
  input  logic        S_ACK,
  input  logic [31:0] S_RDATA,
  output logic        TIMEOUT_PULSE
);
  typedef enum logic [1:0] {IDLE, BUSY, TOUT} state_t;
  state_t      state, state_nx;
  logic        grant, grant_nx, last, last_nx;
  logic [15:0] cnt, cnt_nx;
  logic        g_cs, g_rnw, tmo, busy, tout, ack_g;
  logic [31:0] g_addr, g_wdata, rd_g;
  logic [3:0]  g_be;
  assign g_cs    = grant ? M1_CS    : M0_CS;
  assign g_rnw   = grant ? M1_RNW   : M0_RNW;
  assign g_addr  = grant ? M1_ADDR  : M0_ADDR;
  assign g_be    = grant ? M1_BE    : M0_BE;
  assign g_wdata = grant ? M1_WDATA : M0_WDATA;
  // Compare happens before the increment, so the counter never passes TIMEOUT-1.
  assign tmo = state == BUSY && g_cs && !S_ACK && cnt == 16'(TIMEOUT - 1);
  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx  = last;
    cnt_nx   = cnt;
    case (state)
      IDLE:
        if (M0_CS || M1_CS) begin
          state_nx = BUSY;
          grant_nx = (M0_CS && M1_CS) ? ~last : M1_CS;
          cnt_nx   = '0;
        end
      BUSY:
        if (!g_cs) begin
          state_nx = IDLE;
          last_nx  = grant;
        end else if (tmo) state_nx = TOUT;
        else if (!S_ACK) cnt_nx = cnt + 16'd1;
      TOUT:
        if (!g_cs) begin
          state_nx = IDLE;
          last_nx  = grant;
        end
      default: state_nx = IDLE;
    endcase
  end
  // Outputs are gated by ARESETN so the reset cycle is fully quiet.
  always_comb begin
    busy          = ARESETN && state == BUSY;
    tout          = ARESETN && state == TOUT;
    S_CS          = busy && g_cs;
    S_RNW         = busy && g_rnw;
    S_ADDR        = busy ? g_addr  : '0;
    S_BE          = busy ? g_be    : '0;
    S_WDATA       = busy ? g_wdata : '0;
    ack_g         = busy ? S_ACK : tout;
    rd_g          = busy ? S_RDATA : tout ? ERR_DATA : '0;
    M0_ACK        = !grant && ack_g;
    M1_ACK        = grant && ack_g;
    M0_RDATA      = grant ? '0 : rd_g;
    M1_RDATA      = grant ? rd_g : '0;
    TIMEOUT_PULSE = ARESETN && tmo;
  end
endmodule

// File: tb/tb_aq_local_bus_arbiter.sv
// tb_aq_local_bus_arbiter: table vectors, directed corner sequences and random traffic
// checked against a transaction-level model of the arbiter.
module tb_aq_local_bus_arbiter;
  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic        clk = 0, arst;
  logic        m_cs[2], m_rnw[2], m_ack[2];
  logic [31:0] m_addr[2], m_wdata[2], m_rdata[2];
  logic [3:0]  m_be[2];
  logic        s_cs, s_rnw, s_ack, tpulse;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  int errors = 0, checks = 0;
  int owner = -1, last = 1, waited = 0;
  bit tout = 0;
  always #5 clk = ~clk;
  aq_local_bus_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .ACLK(clk), .ARESETN(arst),
    .M0_CS(m_cs[0]), .M0_RNW(m_rnw[0]), .M0_ADDR(m_addr[0]), .M0_BE(m_be[0]),
    .M0_WDATA(m_wdata[0]), .M0_ACK(m_ack[0]), .M0_RDATA(m_rdata[0]),
    .M1_CS(m_cs[1]), .M1_RNW(m_rnw[1]), .M1_ADDR(m_addr[1]), .M1_BE(m_be[1]),
    .M1_WDATA(m_wdata[1]), .M1_ACK(m_ack[1]), .M1_RDATA(m_rdata[1]),
    .S_CS(s_cs), .S_RNW(s_rnw), .S_ADDR(s_addr), .S_BE(s_be), .S_WDATA(s_wdata),
    .S_ACK(s_ack), .S_RDATA(s_rdata), .TIMEOUT_PULSE(tpulse)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: who owns the target, how long it has waited, whether it timed out.
  task automatic model_check();
    logic e_scs = 0, e_tp = 0, gcs;
    logic e_ack[2] = '{0, 0};
    logic [31:0] e_rd[2] = '{0, 0};
    if (arst && owner >= 0) begin
      gcs = m_cs[owner];
      if (!tout) begin
        e_scs = gcs;
        e_ack[owner] = s_ack;
        e_rd[owner] = s_rdata;
        e_tp = gcs && !s_ack && waited == TMO - 1;
      end else begin
        e_ack[owner] = 1;
        e_rd[owner] = ERR;
      end
    end
    chk("model_s_cs", 32'(s_cs), 32'(e_scs));
    chk("model_m0_ack", 32'(m_ack[0]), 32'(e_ack[0]));
    chk("model_m1_ack", 32'(m_ack[1]), 32'(e_ack[1]));
    chk("model_m0_rdata", m_rdata[0], e_rd[0]);
    chk("model_m1_rdata", m_rdata[1], e_rd[1]);
    chk("model_tpulse", 32'(tpulse), 32'(e_tp));
    if (e_scs) begin
      chk("model_s_rnw", 32'(s_rnw), 32'(m_rnw[owner]));
      chk("model_s_addr", s_addr, m_addr[owner]);
      chk("model_s_be", 32'(s_be), 32'(m_be[owner]));
      chk("model_s_wdata", s_wdata, m_wdata[owner]);
    end
  endtask
  task automatic model_step();
    if (!arst) begin
      owner = -1; last = 1; waited = 0; tout = 0;
    end else if (owner < 0) begin
      if (m_cs[0] || m_cs[1]) begin
        owner = (m_cs[0] && m_cs[1]) ? 1 - last : (m_cs[0] ? 0 : 1);
        waited = 0;
        tout = 0;
      end
    end else if (!m_cs[owner]) begin
      last = owner;
      owner = -1;
    end else if (!tout && !s_ack) begin
      if (waited == TMO - 1) tout = 1;
      else waited++;
    end
  endtask
  task automatic drive(input bit rstn, input bit c0, input bit c1, input bit ack);
    arst = rstn; m_cs[0] = c0; m_cs[1] = c1; s_ack = ack;
    @(negedge clk);
    model_check();
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  typedef struct {bit rstn, cs0, cs1, ack, scs, a0, a1, tp; int gnt;} vec_t;
  vec_t tbl[27];
  initial begin
    tbl[0]  = '{0,1,0,0, 0,0,0,0, 2};
    tbl[1]  = '{1,1,0,0, 0,0,0,0, 2};
    tbl[2]  = '{1,1,0,0, 1,0,0,0, 0};
    tbl[3]  = '{1,1,0,0, 1,0,0,0, 0};
    tbl[4]  = '{1,1,0,1, 1,1,0,0, 0};
    tbl[5]  = '{1,0,0,0, 0,0,0,0, 2};
    tbl[6]  = '{0,0,0,0, 0,0,0,0, 2};
    tbl[7]  = '{1,1,1,0, 0,0,0,0, 2};
    tbl[8]  = '{1,1,1,1, 1,1,0,0, 0};
    tbl[9]  = '{1,0,1,0, 0,0,0,0, 2};
    tbl[10] = '{1,1,1,0, 0,0,0,0, 2};
    tbl[11] = '{1,1,1,1, 1,0,1,0, 1};
    tbl[12] = '{1,1,0,0, 0,0,0,0, 2};
    tbl[13] = '{1,1,1,0, 0,0,0,0, 2};
    tbl[14] = '{1,1,1,1, 1,1,0,0, 0};
    tbl[15] = '{1,0,1,0, 0,0,0,0, 2};
    tbl[16] = '{1,1,1,0, 0,0,0,0, 2};
    tbl[17] = '{1,1,1,1, 1,0,1,0, 1};
    tbl[18] = '{1,0,0,0, 0,0,0,0, 2};
    tbl[19] = '{1,0,0,0, 0,0,0,0, 2};
    tbl[20] = '{1,1,0,0, 0,0,0,0, 2};
    tbl[21] = '{1,1,0,0, 1,0,0,0, 0};
    tbl[22] = '{0,1,0,1, 0,0,0,0, 2};
    tbl[23] = '{1,1,1,0, 0,0,0,0, 2};
    tbl[24] = '{1,1,1,0, 1,0,0,0, 0};
    tbl[25] = '{1,0,0,0, 0,0,0,0, 2};
    tbl[26] = '{1,0,0,0, 0,0,0,0, 2};
    arst = 0; s_ack = 0; s_rdata = 32'h1234_5678;
    m_cs = '{0, 0};
    m_rnw = '{1, 0}; m_addr = '{32'h100, 32'h20}; m_be = '{4'hF, 4'b0011};
    m_wdata = '{32'h0, 32'hA5A5_A5A5};
    @(posedge clk); #1;
    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].rstn, tbl[i].cs0, tbl[i].cs1, tbl[i].ack);
      chk($sformatf("tbl%0d_s_cs", i), 32'(s_cs), 32'(tbl[i].scs));
      chk($sformatf("tbl%0d_m0_ack", i), 32'(m_ack[0]), 32'(tbl[i].a0));
      chk($sformatf("tbl%0d_m1_ack", i), 32'(m_ack[1]), 32'(tbl[i].a1));
      chk($sformatf("tbl%0d_tpulse", i), 32'(tpulse), 32'(tbl[i].tp));
      if (tbl[i].gnt < 2) chk($sformatf("tbl%0d_s_addr", i), s_addr, tbl[i].gnt == 1 ? 32'h20 : 32'h100);
      if (tbl[i].a0) chk($sformatf("tbl%0d_m0_rdata", i), m_rdata[0], 32'h1234_5678);
      tick();
    end
    // M1 write passthrough
    drive(0, 0, 0, 0); tick();
    drive(1, 0, 1, 0); tick();
    drive(1, 0, 1, 0);
    chk("wr_s_cs", 32'(s_cs), 1);
    chk("wr_s_rnw", 32'(s_rnw), 0);
    chk("wr_s_be", 32'(s_be), 32'h3);
    chk("wr_s_wdata", s_wdata, 32'hA5A5_A5A5);
    chk("wr_m1_ack_lo", 32'(m_ack[1]), 0);
    tick();
    drive(1, 0, 1, 1);
    chk("wr_m1_ack_hi", 32'(m_ack[1]), 1);
    tick();
    drive(1, 0, 0, 0); tick();
    // M0 abandons before ACK, waiting M1 takes over
    drive(0, 0, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    drive(1, 1, 1, 0); chk("ab_s_cs_hi", 32'(s_cs), 1); tick();
    drive(1, 0, 1, 0);
    chk("ab_s_cs_drop", 32'(s_cs), 0);
    chk("ab_m0_ack", 32'(m_ack[0]), 0);
    tick();
    drive(1, 0, 1, 0); chk("ab_idle", 32'(s_cs), 0); tick();
    drive(1, 0, 1, 0);
    chk("ab_m1_s_cs", 32'(s_cs), 1);
    chk("ab_m1_addr", s_addr, 32'h20);
    tick();
    drive(1, 0, 1, 1); tick();
    drive(1, 0, 0, 0); tick();
    // Timeout with S_ACK stuck low, M1 pending
    drive(0, 0, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    for (int i = 0; i < TMO; i++) begin
      drive(1, 1, 1, 0);
      chk($sformatf("to_s_cs%0d", i), 32'(s_cs), 1);
      chk($sformatf("to_tpulse%0d", i), 32'(tpulse), 32'(i == TMO - 1));
      tick();
    end
    drive(1, 1, 1, 0);
    chk("to_s_cs_off", 32'(s_cs), 0);
    chk("to_m0_ack", 32'(m_ack[0]), 1);
    chk("to_m0_rdata", m_rdata[0], 32'hDEAD_BEEF);
    chk("to_m1_ack", 32'(m_ack[1]), 0);
    chk("to_tpulse_off", 32'(tpulse), 0);
    tick();
    drive(1, 0, 1, 0); chk("to_release_ack", 32'(m_ack[0]), 1); tick();
    drive(1, 0, 1, 0); chk("to_idle", 32'(s_cs), 0); tick();
    drive(1, 0, 1, 1);
    chk("to_m1_s_cs", 32'(s_cs), 1);
    chk("to_m1_addr", s_addr, 32'h20);
    chk("to_m1_ack", 32'(m_ack[1]), 1);
    tick();
    drive(1, 0, 0, 0); tick();
    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit c[2];
      for (int k = 0; k < 2; k++) begin
        c[k] = m_cs[k] ^ ($urandom_range(0, 3) == 0);
        m_rnw[k] = 1'($urandom);
        m_addr[k] = $urandom;
        m_be[k] = 4'($urandom);
        m_wdata[k] = $urandom;
      end
      s_rdata = $urandom;
      drive($urandom_range(0, 99) != 0, c[0], c[1], $urandom_range(0, 4) == 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
